// File: rtl/serial_cmpl_pkg.sv
// Shared types and constants for the bit-serial two's-complement negator.
package serial_cmpl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      COPY   = 2'd1,
      INVERT = 2'd2
   } cmpl_state_t;

   localparam int CMPL_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_cmpl_cell.sv
// One-bit step of the negator: copy bits until the first one has passed, then invert.
module serial_cmpl_cell
   import serial_cmpl_pkg::*;
(
   input  logic        bit_in,
   input  cmpl_state_t state_in,
   output logic        bit_out,
   output cmpl_state_t state_next
);

   always_comb begin
      bit_out    = (state_in == INVERT) ? ~bit_in : bit_in;
      state_next = state_in;
      // The first one seen while copying is kept as-is; every later bit is inverted.
      if ((state_in == COPY) && bit_in) begin
         state_next = INVERT;
      end
   end

endmodule

// File: rtl/serial_complementor.sv
// Bit-serial two's-complement negator, LSB first, one bit per clock.
// Optional overflow flag output enabled by defining SERIAL_CMPL_OVF_EN.
module serial_complementor
   import serial_cmpl_pkg::*;
#(
   parameter int WIDTH = CMPL_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout
`ifdef SERIAL_CMPL_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   cmpl_state_t      state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef SERIAL_CMPL_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic             cell_bit;
   cmpl_state_t      cell_state;

   serial_cmpl_cell u_cell (
      .bit_in     (shift_q[0]),
      .state_in   (state_q),
      .bit_out    (cell_bit),
      .state_next (cell_state)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      result_d = result_q;
      dout_d   = dout_q;
      count_d  = count_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef SERIAL_CMPL_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d  = din;
               result_d = '0;
               count_d  = '0;
               state_d  = COPY;
               busy_d   = 1'b1;
            end
         end
         COPY, INVERT: begin
            // Result fills from the MSB side so bit 0 lands at position 0 after WIDTH steps.
            shift_d  = shift_q >> 1;
            result_d = {cell_bit, result_q[WIDTH-1:1]};
            count_d  = count_q + CNT_W'(1);
            state_d  = cell_state;
            if (count_q == LAST) begin
               state_d = IDLE;
               dout_d  = result_d;
               done_d  = 1'b1;
               busy_d  = 1'b0;
`ifdef SERIAL_CMPL_OVF_EN
               ovf_d   = (state_q == COPY) && shift_q[0];
`endif
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         result_q <= '0;
         dout_q   <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_CMPL_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         result_q <= result_d;
         dout_q   <= dout_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERIAL_CMPL_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;
`ifdef SERIAL_CMPL_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_complementor.sv
// Randomized self-checking bench for serial_complementor against an arithmetic negation model.
module tb_serial_complementor;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] din;
   logic         busy;
   logic         done;
   logic [W-1:0] dout;
`ifdef SERIAL_CMPL_OVF_EN
   logic         ovf;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   serial_complementor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din),
      .busy  (busy),
      .done  (done),
      .dout  (dout)
`ifdef SERIAL_CMPL_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: negation as plain modular arithmetic, independent of any bit-serial rule.
   function automatic logic [W-1:0] model_neg(input logic [W-1:0] d);
      int unsigned v;
      v = ((1 << W) - int'(d)) % (1 << W);
      return W'(v);
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] d);
      return d == W'(1 << (W - 1));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches one operation and waits (bounded) for its done pulse; leaves time in the done cycle.
   task automatic do_op(input logic [W-1:0] d, output logic [W-1:0] res, output logic res_ovf,
                        output int lat, output int busy_bad);
      start = 1'b1;
      din   = d;
      tick();
      start = 1'b0;
      din   = W'($urandom);
      lat      = 0;
      busy_bad = 0;
      res_ovf  = 1'b0;
      while (done !== 1'b1 && lat <= 100) begin
         if (busy !== 1'b1) busy_bad++;
         tick();
         lat++;
      end
      res = dout;
`ifdef SERIAL_CMPL_OVF_EN
      res_ovf = ovf;
`endif
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      #2;
      n_cmp++;
      if ({busy, done, dout} !== {1'b0, 1'b0, W'(0)}) begin
         n_bad++;
         $display("[TB] FAIL reset_outputs: got busy=%b done=%b dout=%h, want 0/0/00", busy, done, dout);
      end
      tick();
      tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({busy, done, dout} !== {1'b0, 1'b0, W'(0)}) begin
         n_bad++;
         $display("[TB] FAIL idle_after_reset: got busy=%b done=%b dout=%h, want 0/0/00", busy, done, dout);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0] vec [5];
      logic [W-1:0] res;
      logic         res_ovf;
      int           lat;
      int           bb;
      vec = '{8'b10000010, 8'h00, 8'h80, 8'h7F, 8'h3C};
      foreach (vec[i]) begin
         do_op(vec[i], res, res_ovf, lat, bb);
         n_cmp++;
         if (res !== model_neg(vec[i]) || lat != W || bb != 0) begin
            n_bad++;
            $display("[TB] FAIL directed_%h: got dout=%h lat=%0d busy_drops=%0d, want dout=%h lat=%0d busy_drops=0",
                     vec[i], res, lat, bb, model_neg(vec[i]), W);
         end
`ifdef SERIAL_CMPL_OVF_EN
         n_cmp++;
         if (res_ovf !== model_ovf(vec[i])) begin
            n_bad++;
            $display("[TB] FAIL ovf_%h: got %b, want %b", vec[i], res_ovf, model_ovf(vec[i]));
         end
`endif
         tick();
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0 || dout !== res) begin
            n_bad++;
            $display("[TB] FAIL pulse_width_%h: got done=%b busy=%b dout=%h, want 0/0/%h",
                     vec[i], done, busy, dout, res);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] res;
      logic         res_ovf;
      int           lat;
      int           bb;
      do_op(8'hFF, res, res_ovf, lat, bb);
      n_cmp++;
      if (res !== 8'h01 || lat != W) begin
         n_bad++;
         $display("[TB] FAIL b2b_first: got dout=%h lat=%0d, want 01 lat=%0d", res, lat, W);
      end
      do_op(8'h01, res, res_ovf, lat, bb);
      n_cmp++;
      if (res !== 8'hFF || lat != W || bb != 0) begin
         n_bad++;
         $display("[TB] FAIL b2b_second: got dout=%h lat=%0d busy_drops=%0d, want FF lat=%0d busy_drops=0",
                  res, lat, bb, W);
      end
      tick();
   endtask

   task automatic test_ignore_start();
      int           pulses;
      int           first_lat;
      logic [W-1:0] first_dout;
      pulses     = 0;
      first_lat  = -1;
      first_dout = '0;
      start = 1'b1;
      din   = 8'h05;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k == 3) begin
            start = 1'b1;
            din   = 8'hAA;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done === 1'b1) begin
            pulses++;
            if (first_lat < 0) begin
               first_lat  = k;
               first_dout = dout;
            end
         end
      end
      start = 1'b0;
      n_cmp++;
      if (pulses != 1 || first_lat != W || first_dout !== 8'hFB) begin
         n_bad++;
         $display("[TB] FAIL ignore_start: got pulses=%0d lat=%0d dout=%h, want 1 %0d FB",
                  pulses, first_lat, first_dout, W);
      end
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] res;
      logic         res_ovf;
      int           lat;
      int           bb;
      int           pulses;
      pulses = 0;
      start = 1'b1;
      din   = 8'h3C;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || dout !== '0 || done !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL abort_immediate: got busy=%b done=%b dout=%h, want 0/0/00", busy, done, dout);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      n_cmp++;
      if (pulses != 0 || dout !== '0) begin
         n_bad++;
         $display("[TB] FAIL abort_no_done: got pulses=%0d dout=%h, want 0 and 00", pulses, dout);
      end
      do_op(8'h3C, res, res_ovf, lat, bb);
      n_cmp++;
      if (res !== 8'hC4 || lat != W) begin
         n_bad++;
         $display("[TB] FAIL after_abort: got dout=%h lat=%0d, want C4 lat=%0d", res, lat, W);
      end
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] d;
      logic [W-1:0] res;
      logic         res_ovf;
      int           lat;
      int           bb;
      for (int n = 0; n < 40; n++) begin
         d = W'($urandom);
         do_op(d, res, res_ovf, lat, bb);
         n_cmp++;
         if (res !== model_neg(d) || lat != W || bb != 0) begin
            n_bad++;
            $display("[TB] FAIL random_%0d din=%h: got dout=%h lat=%0d busy_drops=%0d, want %h lat=%0d",
                     n, d, res, lat, bb, model_neg(d), W);
         end
`ifdef SERIAL_CMPL_OVF_EN
         n_cmp++;
         if (res_ovf !== model_ovf(d)) begin
            n_bad++;
            $display("[TB] FAIL random_ovf_%0d din=%h: got %b, want %b", n, d, res_ovf, model_ovf(d));
         end
`endif
         for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_ignore_start();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
